// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and arbitrates six raw keypad
// buttons. Each accepted press becomes one single-cycle pulse on BTNA..BTNF.
// Only one key is accepted at a time, and all keys must be released before
// the next press is accepted.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] BTN_IN,
  output logic       BTNA,
  output logic       BTNB,
  output logic       BTNC,
  output logic       BTND,
  output logic       BTNE,
  output logic       BTNF,
  output logic [5:0] BTN_STABLE,
  output logic       BUSY
);

  // Counter value at which a persistent difference is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  logic [5:0] meta_reg;
  logic [5:0] sync_reg;
  logic [5:0] stable_reg;
  state_t     state_reg;
  state_t     state_next;
  logic [5:0] pulse_reg;
  logic [5:0] pulse_next;

  // Two-flop synchroniser. It brings the asynchronous button levels into CLK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= BTN_IN;
      sync_reg <= meta_reg;
    end
  end

  // One independent debouncer per channel. A new level is adopted only after
  // it has persisted for DEBOUNCE_CYCLES consecutive cycles.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;

      // Count consecutive disagreements between the synchronised input and the
      // debounced level. Any agreement restarts the count.
      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          level_reg <= sync_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign stable_reg[gi] = level_reg;
    end
  endgenerate

  // Arbiter state and registered press pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      pulse_reg <= '0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
    end
  end

  // Next-state logic. In IDLE, the lowest-numbered stable key wins and fires
  // once. The arbiter then waits in HELD until every key is released, so keys
  // pressed meanwhile are dropped rather than queued.
  always_comb begin
    state_next = state_reg;
    pulse_next = '0;
    case (state_reg)
      IDLE: begin
        if (stable_reg != '0) begin
          // Two's-complement trick isolates the lowest set bit.
          pulse_next = stable_reg & (~stable_reg + 6'd1);
          state_next = HELD;
        end
      end
      HELD: begin
        if (stable_reg == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign BTNA       = pulse_reg[0];
  assign BTNB       = pulse_reg[1];
  assign BTNC       = pulse_reg[2];
  assign BTND       = pulse_reg[3];
  assign BTNE       = pulse_reg[4];
  assign BTNF       = pulse_reg[5];
  assign BTN_STABLE = stable_reg;
  assign BUSY       = (state_reg == HELD);

endmodule
